// File: rtl/mixer_tune_ctrl.sv
// Retune sequencer for the receive mixer path.
// Accepts NCO tuning words over valid/ready, owns the phase accumulator that
// feeds the sine/cosine LUT, and blanks mix_enable for a settle window after
// every applied retune so mixer latency and filter transients can flush.
module mixer_tune_ctrl #(
  parameter int PHASE_WIDTH   = 26,
  parameter int SETTLE_CYCLES = 64
) (
  input  logic                   clk,
  input  logic                   arst,
  input  logic                   tune_valid,
  output logic                   tune_ready,
  input  logic [PHASE_WIDTH-1:0] tune_word,
  input  logic                   tune_phase_clear,
  output logic [PHASE_WIDTH-1:0] phase_out,
  output logic [PHASE_WIDTH-1:0] active_word,
  output logic                   mix_enable,
  output logic                   settling,
  output logic [7:0]             retune_count
);

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    APPLY  = 2'd1,
    SETTLE = 2'd2,
    RUN    = 2'd3
  } state_t;

  // Counter counts down from SETTLE_CYCLES-1 so that SETTLE lasts exactly
  // SETTLE_CYCLES cycles including the one where the count reaches zero.
  localparam logic [15:0] SETTLE_LOAD = 16'(SETTLE_CYCLES - 1);

  state_t                 state_reg, state_next;
  logic [PHASE_WIDTH-1:0] pend_word_reg;
  logic                   pend_clear_reg;
  logic [PHASE_WIDTH-1:0] phase_reg, phase_next;
  logic [PHASE_WIDTH-1:0] active_reg, active_next;
  logic [15:0]            settle_cnt_reg, settle_cnt_next;
  logic [7:0]             count_reg, count_next;
  logic [PHASE_WIDTH-1:0] phase_step;
  logic                   xfer;

  assign tune_ready   = (state_reg != APPLY);
  assign xfer         = tune_valid && tune_ready;
  assign mix_enable   = (state_reg == RUN);
  assign settling     = (state_reg == SETTLE);
  assign phase_out    = phase_reg;
  assign active_word  = active_reg;
  assign retune_count = count_reg;

  // Carry-out is discarded: the accumulator wraps modulo 2^PHASE_WIDTH.
  assign phase_step = phase_reg + active_reg;

  // Next-state, accumulator, settle counter and retune counter updates.
  always_comb begin
    state_next      = state_reg;
    phase_next      = phase_reg;
    active_next     = active_reg;
    settle_cnt_next = settle_cnt_reg;
    count_next      = count_reg;
    case (state_reg)
      IDLE: begin
        phase_next = '0;
        if (xfer) state_next = APPLY;
      end
      APPLY: begin
        // The old word keeps driving the step on the exit edge; the new word
        // takes effect from the first SETTLE cycle onward.
        phase_next      = pend_clear_reg ? '0 : phase_step;
        active_next     = pend_word_reg;
        settle_cnt_next = SETTLE_LOAD;
        count_next      = count_reg + 8'd1;
        state_next      = SETTLE;
      end
      SETTLE: begin
        phase_next = phase_step;
        if (settle_cnt_reg != 16'd0) settle_cnt_next = settle_cnt_reg - 16'd1;
        // A new request restarts the whole window via APPLY.
        if (xfer) state_next = APPLY;
        else if (settle_cnt_reg == 16'd0) state_next = RUN;
      end
      RUN: begin
        phase_next = phase_step;
        if (xfer) state_next = APPLY;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

  // State and datapath registers; a reset drops any pending request.
  always_ff @(posedge clk) begin
    if (arst) begin
      state_reg      <= IDLE;
      pend_word_reg  <= '0;
      pend_clear_reg <= 1'b0;
      phase_reg      <= '0;
      active_reg     <= '0;
      settle_cnt_reg <= '0;
      count_reg      <= '0;
    end else begin
      state_reg      <= state_next;
      phase_reg      <= phase_next;
      active_reg     <= active_next;
      settle_cnt_reg <= settle_cnt_next;
      count_reg      <= count_next;
      if (xfer) begin
        pend_word_reg  <= tune_word;
        pend_clear_reg <= tune_phase_clear;
      end
    end
  end

endmodule

// File: tb/tb_mixer_tune_ctrl.sv
// Bench for mixer_tune_ctrl: a per-cycle vector table on a SETTLE_CYCLES=4
// instance, plus hand sequences for back-to-back transfers, 256-retune wrap
// and a retune inside the settle window on a SETTLE_CYCLES=8 instance.
module tb_mixer_tune_ctrl;

  localparam int PW = 26;

  logic          clk = 1'b0;
  logic          arst;
  logic          tune_valid;
  logic [PW-1:0] tune_word;
  logic          tune_phase_clear;

  logic          ready4, mix4, settling4;
  logic [PW-1:0] phase4, active4;
  logic [7:0]    count4;
  logic          ready8, mix8, settling8;
  logic [PW-1:0] phase8, active8;
  logic [7:0]    count8;

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  mixer_tune_ctrl #(.PHASE_WIDTH(PW), .SETTLE_CYCLES(4)) dut4 (
    .clk(clk), .arst(arst), .tune_valid(tune_valid), .tune_ready(ready4),
    .tune_word(tune_word), .tune_phase_clear(tune_phase_clear),
    .phase_out(phase4), .active_word(active4), .mix_enable(mix4),
    .settling(settling4), .retune_count(count4)
  );

  mixer_tune_ctrl #(.PHASE_WIDTH(PW), .SETTLE_CYCLES(8)) dut8 (
    .clk(clk), .arst(arst), .tune_valid(tune_valid), .tune_ready(ready8),
    .tune_word(tune_word), .tune_phase_clear(tune_phase_clear),
    .phase_out(phase8), .active_word(active8), .mix_enable(mix8),
    .settling(settling8), .retune_count(count8)
  );

  typedef struct {
    logic          a;
    logic          v;
    logic [PW-1:0] w;
    logic          c;
    logic          rdy;
    logic [PW-1:0] ph;
    logic [PW-1:0] act;
    logic          mix;
    logic          set;
    logic [7:0]    cnt;
  } vec_t;

  vec_t tbl[29];

  function automatic vec_t mk(logic a, logic v, logic [PW-1:0] w, logic c,
                              logic rdy, logic [PW-1:0] ph, logic [PW-1:0] act,
                              logic mix, logic set, logic [7:0] cnt);
    vec_t r;
    r.a = a; r.v = v; r.w = w; r.c = c;
    r.rdy = rdy; r.ph = ph; r.act = act; r.mix = mix; r.set = set; r.cnt = cnt;
    return r;
  endfunction

  task automatic check(input string name, input int idx,
                       input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s @%0d: got 0x%0h, required 0x%0h", name, idx, got, exp);
    end
  endtask

  initial begin
    // inputs during the cycle | expected outputs of that cycle
    //            a  v  word        c   rdy phase       active      mix set cnt
    // Reset held with valid high: no transfer may happen.
    tbl[0]  = mk(1, 1, 26'h123,     0,  1, 26'h0,       26'h0,       0, 0, 0);
    tbl[1]  = mk(1, 1, 26'h123,     0,  1, 26'h0,       26'h0,       0, 0, 0);
    tbl[2]  = mk(1, 1, 26'h123,     0,  1, 26'h0,       26'h0,       0, 0, 0);
    tbl[3]  = mk(0, 0, 26'h0,       0,  1, 26'h0,       26'h0,       0, 0, 0);
    // Single retune with clear, transfer at the end of row 4.
    tbl[4]  = mk(0, 1, 26'h0100000, 1,  1, 26'h0,       26'h0,       0, 0, 0);
    tbl[5]  = mk(0, 0, 26'h0,       0,  0, 26'h0,       26'h0,       0, 0, 0);
    tbl[6]  = mk(0, 0, 26'h0,       0,  1, 26'h0,       26'h0100000, 0, 1, 1);
    tbl[7]  = mk(0, 0, 26'h0,       0,  1, 26'h0100000, 26'h0100000, 0, 1, 1);
    tbl[8]  = mk(0, 0, 26'h0,       0,  1, 26'h0200000, 26'h0100000, 0, 1, 1);
    tbl[9]  = mk(0, 0, 26'h0,       0,  1, 26'h0300000, 26'h0100000, 0, 1, 1);
    tbl[10] = mk(0, 0, 26'h0,       0,  1, 26'h0400000, 26'h0100000, 1, 0, 1);
    // Retune from RUN to 0x10 with clear.
    tbl[11] = mk(0, 1, 26'h10,      1,  1, 26'h0500000, 26'h0100000, 1, 0, 1);
    tbl[12] = mk(0, 0, 26'h0,       0,  0, 26'h0600000, 26'h0100000, 0, 0, 1);
    tbl[13] = mk(0, 0, 26'h0,       0,  1, 26'h0,       26'h10,      0, 1, 2);
    tbl[14] = mk(0, 0, 26'h0,       0,  1, 26'h10,      26'h10,      0, 1, 2);
    tbl[15] = mk(0, 0, 26'h0,       0,  1, 26'h20,      26'h10,      0, 1, 2);
    tbl[16] = mk(0, 0, 26'h0,       0,  1, 26'h30,      26'h10,      0, 1, 2);
    // Continuous-phase retune to 0x20 from RUN, no clear.
    tbl[17] = mk(0, 1, 26'h20,      0,  1, 26'h40,      26'h10,      1, 0, 2);
    tbl[18] = mk(0, 0, 26'h0,       0,  0, 26'h50,      26'h10,      0, 0, 2);
    tbl[19] = mk(0, 0, 26'h0,       0,  1, 26'h60,      26'h20,      0, 1, 3);
    tbl[20] = mk(0, 0, 26'h0,       0,  1, 26'h80,      26'h20,      0, 1, 3);
    // Wrap-around word applied from SETTLE with clear.
    tbl[21] = mk(0, 1, 26'h3FFFFFF, 1,  1, 26'hA0,      26'h20,      0, 1, 3);
    tbl[22] = mk(0, 0, 26'h0,       0,  0, 26'hC0,      26'h20,      0, 0, 3);
    tbl[23] = mk(0, 0, 26'h0,       0,  1, 26'h0,       26'h3FFFFFF, 0, 1, 4);
    tbl[24] = mk(0, 0, 26'h0,       0,  1, 26'h3FFFFFF, 26'h3FFFFFF, 0, 1, 4);
    // Reset for one edge in the middle of SETTLE.
    tbl[25] = mk(1, 0, 26'h0,       0,  1, 26'h3FFFFFE, 26'h3FFFFFF, 0, 1, 4);
    tbl[26] = mk(0, 0, 26'h0,       0,  1, 26'h0,       26'h0,       0, 0, 0);
    tbl[27] = mk(0, 0, 26'h0,       0,  1, 26'h0,       26'h0,       0, 0, 0);
    tbl[28] = mk(0, 0, 26'h0,       0,  1, 26'h0,       26'h0,       0, 0, 0);

    arst = 1'b1;
    tune_valid = 1'b1;
    tune_word = 26'h123;
    tune_phase_clear = 1'b0;

    for (int i = 0; i < 29; i++) begin
      @(posedge clk);
      #1;
      check("ready",    i, 32'(ready4),    32'(tbl[i].rdy));
      check("phase",    i, 32'(phase4),    32'(tbl[i].ph));
      check("active",   i, 32'(active4),   32'(tbl[i].act));
      check("mix",      i, 32'(mix4),      32'(tbl[i].mix));
      check("settling", i, 32'(settling4), 32'(tbl[i].set));
      check("count",    i, 32'(count4),    32'(tbl[i].cnt));
      arst = tbl[i].a;
      tune_valid = tbl[i].v;
      tune_word = tbl[i].w;
      tune_phase_clear = tbl[i].c;
    end

    // Back-to-back: valid held high gives one transfer every other cycle;
    // 256 applied retunes bring retune_count back to 0.
    tune_valid = 1'b1;
    tune_word = 26'h1;
    tune_phase_clear = 1'b0;
    for (int i = 0; i < 512; i++) begin
      @(posedge clk);
      #1;
      check("b2b_ready", i, 32'(ready4), (i % 2 == 0) ? 32'd0 : 32'd1);
      if (i % 2 == 1)
        check("b2b_count", i, 32'(count4), 32'(((i + 1) / 2) % 256));
    end
    tune_valid = 1'b0;

    // Retune three cycles into SETTLE on the 8-cycle instance.
    arst = 1'b1;
    @(posedge clk);
    #1;
    arst = 1'b0;
    check("s8_reset_count", 0, 32'(count8), 32'd0);
    tune_valid = 1'b1;
    tune_word = 26'h40;
    tune_phase_clear = 1'b1;
    @(posedge clk);
    #1;
    tune_valid = 1'b0;
    check("s8_apply1_ready", 1, 32'(ready8), 32'd0);
    for (int j = 2; j <= 4; j++) begin
      @(posedge clk);
      #1;
      check("s8_settle1", j, 32'(settling8), 32'd1);
      check("s8_mix1", j, 32'(mix8), 32'd0);
    end
    tune_valid = 1'b1;
    tune_word = 26'h80;
    for (int j = 1; j <= 10; j++) begin
      @(posedge clk);
      #1;
      tune_valid = 1'b0;
      check("s8_mix2", j, 32'(mix8), (j == 10) ? 32'd1 : 32'd0);
      check("s8_settle2", j, 32'(settling8), (j >= 2 && j <= 9) ? 32'd1 : 32'd0);
      if (j == 2) begin
        check("s8_phase_clr", j, 32'(phase8), 32'd0);
        check("s8_active", j, 32'(active8), 32'h80);
      end
    end
    check("s8_count", 10, 32'(count8), 32'd2);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
